// File: rtl/sa_stream.sv
// Weight-stationary N x K systolic matrix-vector stream: y = x * W per row.
// Input rows are skewed into the PE grid; result columns are deskewed so a row emerges at once.
module sa_stream #(
    parameter int N          = 3,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_load,
    input  logic [DATA_WIDTH*N*K-1:0]    w_data,
    output logic                         w_ready,
    input  logic                         relu_en,
    input  logic                         x_valid,
    input  logic [DATA_WIDTH*N-1:0]      x_data,
    output logic                         x_ready,
    output logic                         y_valid,
    output logic [ACC_WIDTH*K-1:0]       y_data,
    input  logic                         y_ready,
    output logic                         busy,
    output logic [31:0]                  rows_out
);

    localparam int L  = N + K - 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(N + K + 2) + 1;

    typedef enum logic [1:0] {NOWGT, READY, LOAD} state_t;

    state_t                        state_q;
    logic                          adv, fire, deliver;
    logic [CW-1:0]                 inflight_q;
    logic [31:0]                   rows_q;
    logic [L-1:0]                  v_q, r_q;
    logic                          y_valid_q;
    logic [ACC_WIDTH*K-1:0]        y_q, y_d;

    logic signed [DATA_WIDTH-1:0]  wq     [N][K];
    logic signed [DATA_WIDTH-1:0]  xq     [N][K];
    logic signed [ACC_WIDTH-1:0]   accq   [N][K];
    logic signed [DATA_WIDTH-1:0]  xin    [N][K];
    logic signed [ACC_WIDTH-1:0]   pin    [N][K];
    logic signed [ACC_WIDTH-1:0]   acc_d  [N][K];
    logic signed [DATA_WIDTH-1:0]  x_in   [N];
    logic signed [DATA_WIDTH-1:0]  skew_o [N];
    logic signed [ACC_WIDTH-1:0]   col_o  [K];

    assign adv      = !(y_valid_q && !y_ready);
    assign x_ready  = (state_q == READY) && adv && !w_load;
    assign fire     = x_valid && x_ready;
    assign deliver  = y_valid_q && y_ready;
    assign busy     = (inflight_q != '0);
    assign w_ready  = (state_q == NOWGT) || ((state_q == READY) && !busy);
    assign y_valid  = y_valid_q;
    assign y_data   = y_q;
    assign rows_out = rows_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NOWGT;
        end else begin
            unique case (state_q)
                NOWGT:   if (w_load && w_ready) state_q <= LOAD;
                READY:   if (w_load && w_ready) state_q <= LOAD;
                LOAD:    state_q <= READY;
                default: state_q <= NOWGT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    wq[n][k] <= '0;
        end else if (state_q == LOAD) begin
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    wq[n][k] <= w_data[(n*K+k)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Bubbles enter as zeros; their valid tag keeps them from ever reaching y.
    always_comb begin
        for (int n = 0; n < N; n++)
            x_in[n] = fire ? x_data[n*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    for (genvar n = 0; n < N; n++) begin : g_skew
        if (n == 0) begin : g_direct
            assign skew_o[n] = x_in[n];
        end else begin : g_regs
            logic signed [DATA_WIDTH-1:0] sk_q [n];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < n; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= x_in[n];
                    for (int i = 1; i < n; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign skew_o[n] = sk_q[n-1];
        end
    end

    always_comb begin
        for (int n = 0; n < N; n++) begin
            xin[n][0] = skew_o[n];
            for (int k = 1; k < K; k++)
                xin[n][k] = xq[n][k-1];
        end
        for (int k = 0; k < K; k++) begin
            pin[0][k] = '0;
            for (int n = 1; n < N; n++)
                pin[n][k] = accq[n-1][k];
        end
        for (int n = 0; n < N; n++)
            for (int k = 0; k < K; k++)
                acc_d[n][k] = pin[n][k]
                    + ACC_WIDTH'(PW'(xin[n][k]) * PW'(wq[n][k]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++) begin
                    xq[n][k]   <= '0;
                    accq[n][k] <= '0;
                end
        end else if (adv) begin
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++) begin
                    xq[n][k]   <= xin[n][k];
                    accq[n][k] <= acc_d[n][k];
                end
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_desk
        localparam int D = K - 1 - k;
        if (D == 0) begin : g_direct
            assign col_o[k] = accq[N-1][k];
        end else begin : g_regs
            logic signed [ACC_WIDTH-1:0] ds_q [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) ds_q[i] <= '0;
                end else if (adv) begin
                    ds_q[0] <= accq[N-1][k];
                    for (int i = 1; i < D; i++) ds_q[i] <= ds_q[i-1];
                end
            end
            assign col_o[k] = ds_q[D-1];
        end
    end

    // Valid and relu tags travel alongside the wavefront, aligned with the deskew output.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            r_q <= '0;
        end else if (adv) begin
            v_q <= {v_q[L-2:0], fire};
            r_q <= {r_q[L-2:0], fire && relu_en};
        end
    end

    always_comb begin
        y_d = '0;
        for (int k = 0; k < K; k++)
            y_d[k*ACC_WIDTH +: ACC_WIDTH] =
                (r_q[L-1] && col_o[k][ACC_WIDTH-1]) ? '0 : col_o[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid_q <= 1'b0;
            y_q       <= '0;
        end else if (adv) begin
            y_valid_q <= v_q[L-1];
            y_q       <= y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            rows_q     <= '0;
        end else begin
            if (fire && !deliver)
                inflight_q <= inflight_q + CW'(1);
            else if (!fire && deliver)
                inflight_q <= inflight_q - CW'(1);
            if (deliver)
                rows_q <= rows_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_sa_stream.sv
// Scoreboard bench for sa_stream: directed rows push expected results,
// a negedge monitor pops and compares every delivered row.
module tb_sa_stream;

    localparam int N  = 3;
    localparam int K  = 4;
    localparam int DW = 16;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            w_load;
    logic [DW*N*K-1:0] w_data;
    logic            w_ready;
    logic            relu_en;
    logic            x_valid;
    logic [DW*N-1:0] x_data;
    logic            x_ready;
    logic            y_valid;
    logic [AW*K-1:0] y_data;
    logic            y_ready;
    logic            busy;
    logic [31:0]     rows_out;

    always #5 clk = ~clk;

    sa_stream #(.N(N), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .w_load(w_load), .w_data(w_data), .w_ready(w_ready),
        .relu_en(relu_en),
        .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .busy(busy), .rows_out(rows_out)
    );

    logic [127:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    always @(negedge clk) begin
        if (!rst && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL y_extra: got %h expected no row", y_data);
            end else begin
                chk("y_row", 128'(y_data), exp_q.pop_front());
            end
        end
    end

    function automatic logic [DW*N*K-1:0] wmat(input int m);
        logic [DW*N*K-1:0] w;
        logic [15:0] v;
        w = '0;
        for (int n = 0; n < N; n++)
            for (int k = 0; k < K; k++) begin
                case (m)
                    0:       v = 16'd1;
                    1:       v = 16'(k + 1);
                    2:       v = 16'd2;
                    default: v = (n == 0 && k == 0) ? 16'h7FFF : 16'd0;
                endcase
                w[(n*K+k)*DW +: DW] = v;
            end
        return w;
    endfunction

    function automatic logic [DW*N-1:0] xrow(input int a, input int b, input int c);
        return {c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [127:0] yrow(input int a, input int b,
                                          input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x_valid = 1'b0;
        w_load = 1'b0;
        relu_en = 1'b0;
        y_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic load_w(input logic [DW*N*K-1:0] w);
        int i;
        w_data = w;
        w_load = 1'b1;
        for (i = 0; i < 50 && !w_ready; i++) tick();
        if (!w_ready) tmo("load_w");
        tick();
        w_load = 1'b0;
        tick();
    endtask

    task automatic put(input logic [DW*N-1:0] x, input logic r,
                       input logic [127:0] e, input logic push);
        int i;
        x_valid = 1'b1;
        x_data = x;
        relu_en = r;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (x_ready) break;
        end
        if (i == 100) begin
            tmo("put");
            x_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) tmo(nm);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first;
        int seen;
        rst = 1'b1;
        w_load = 1'b0;
        w_data = '0;
        relu_en = 1'b0;
        x_valid = 1'b0;
        x_data = '0;
        y_ready = 1'b1;

        // reset state and ones weights with latency
        do_reset();
        chk("rst_y_valid", 128'(y_valid), 128'(0));
        chk("rst_x_ready", 128'(x_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_y_data", 128'(y_data), 128'(0));
        chk("rst_rows_out", 128'(rows_out), 128'(0));
        chk("rst_w_ready", 128'(w_ready), 128'(1));
        load_w(wmat(0));
        put(xrow(1, 2, 3), 1'b0, yrow(6, 6, 6, 6), 1'b1);
        x_valid = 1'b0;
        first = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (y_valid) begin
                first = j;
                break;
            end
        end
        chk("latency", 128'(first), 128'(6));
        drain("drain_ones");
        chk("ones_rows_out", 128'(rows_out), 128'(1));
        chk("ones_busy", 128'(busy), 128'(0));

        // sign and relu back-to-back
        do_reset();
        load_w(wmat(1));
        put(xrow(-1, -2, -3), 1'b0, yrow(-6, -12, -18, -24), 1'b1);
        put(xrow(-1, -2, -3), 1'b1, yrow(0, 0, 0, 0), 1'b1);
        x_valid = 1'b0;
        first = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (y_valid) begin
                first = j;
                break;
            end
        end
        if (first < 0) tmo("relu_first");
        @(negedge clk);
        chk("relu_b2b_valid", 128'(y_valid), 128'(1));
        drain("drain_relu");

        // back-pressure
        do_reset();
        load_w(wmat(0));
        fork
            begin
                for (int i = 1; i <= 10; i++)
                    put(xrow(i, 0, 0), 1'b0, yrow(i, i, i, i), 1'b1);
                x_valid = 1'b0;
            end
            begin
                int j;
                for (j = 0; j < 50; j++) begin
                    @(negedge clk);
                    if (y_valid) break;
                end
                if (j == 50) tmo("bp_first");
                @(posedge clk);
                #1;
                y_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_x_ready", 128'(x_ready), 128'(0));
                    chk("stall_y_valid", 128'(y_valid), 128'(1));
                    chk("stall_y_hold", 128'(y_data), yrow(2, 2, 2, 2));
                end
                @(posedge clk);
                #1;
                y_ready = 1'b1;
            end
        join
        drain("drain_bp");
        chk("bp_rows_out", 128'(rows_out), 128'(10));

        // weight-load lockout while busy
        do_reset();
        load_w(wmat(0));
        put(xrow(1, 1, 1), 1'b0, yrow(3, 3, 3, 3), 1'b1);
        put(xrow(1, 1, 1), 1'b0, yrow(3, 3, 3, 3), 1'b1);
        x_valid = 1'b0;
        w_data = wmat(2);
        w_load = 1'b1;
        @(negedge clk);
        chk("lock_w_ready", 128'(w_ready), 128'(0));
        chk("lock_busy", 128'(busy), 128'(1));
        tick();
        w_load = 1'b0;
        drain("drain_lock");
        chk("free_w_ready", 128'(w_ready), 128'(1));
        load_w(wmat(2));
        put(xrow(1, 1, 1), 1'b0, yrow(6, 6, 6, 6), 1'b1);
        x_valid = 1'b0;
        drain("drain_twos");

        // mid-stream reset discards in-flight rows
        do_reset();
        load_w(wmat(0));
        for (int i = 1; i <= 3; i++)
            put(xrow(i, i, i), 1'b0, '0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        x_valid = 1'b1;
        x_data = xrow(5, 5, 5);
        seen = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (y_valid) seen++;
        end
        chk("mrst_no_y", 128'(seen), 128'(0));
        chk("mrst_x_ready", 128'(x_ready), 128'(0));
        chk("mrst_w_ready", 128'(w_ready), 128'(1));
        chk("mrst_busy", 128'(busy), 128'(0));
        chk("mrst_rows_out", 128'(rows_out), 128'(0));
        x_valid = 1'b0;
        tick();
        load_w(wmat(0));
        @(negedge clk);
        chk("mrst_x_ready_after", 128'(x_ready), 128'(1));
        tick();
        put(xrow(1, 2, 3), 1'b0, yrow(6, 6, 6, 6), 1'b1);
        x_valid = 1'b0;
        drain("drain_mrst");

        // overflow wrap
        do_reset();
        load_w(wmat(3));
        put(xrow(32'h7FFF, 0, 0), 1'b0, yrow(32'h3FFF0001, 0, 0, 0), 1'b1);
        x_valid = 1'b0;
        drain("drain_ovf");
        chk("ovf_rows_out", 128'(rows_out), 128'(1));

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_stream.md
SA_STREAM -- requirements
Module: sa_stream

Interface
REQ-001 Parameter N, default 3: input vector length, i.e. systolic array rows.
REQ-002 Parameter K, default 4: output vector length, i.e. systolic array columns.
REQ-003 Parameter DATA_WIDTH, default 16: signed width of each X and W element.
REQ-004 Parameter ACC_WIDTH, default 32: signed width of each accumulator and Y element; ACC_WIDTH >= 2*DATA_WIDTH.
REQ-005 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port w_load, input, 1: weight-load request.
REQ-008 Port w_data, input, DATA_WIDTH*N*K: weights; element (n,k) at bits [(n*K+k)*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port w_ready, output, 1: weights may be loaded this cycle.
REQ-010 Port relu_en, input, 1: clamp negative outputs to 0; sampled per row when that row is accepted.
REQ-011 Port x_valid, input, 1: x_data holds a valid row.
REQ-012 Port x_data, input, DATA_WIDTH*N: one input row; element n at [n*DATA_WIDTH +: DATA_WIDTH].
REQ-013 Port x_ready, output, 1: row accepted when x_valid and x_ready are both high.
REQ-014 Port y_valid, output, 1: y_data holds a result row.
REQ-015 Port y_data, output, ACC_WIDTH*K: result row; element k at [k*ACC_WIDTH +: ACC_WIDTH].
REQ-016 Port y_ready, input, 1: downstream accepts y_data.
REQ-017 Port busy, output, 1: at least one accepted row has not yet been delivered.
REQ-018 Port rows_out, output, 32: count of delivered rows (y_valid and y_ready both high); wraps modulo 2^32.

Function
REQ-019 y_data[k] SHALL equal the sum over n of x[n]*W(n,k), computed as a signed full product, sign-extended and summed modulo 2^ACC_WIDTH (wrap, no saturation).
REQ-020 If the row's captured relu_en was 1 and the result element is negative, that element SHALL be output as 0.
REQ-021 Internally: weight-stationary N x K PE grid.
- Input element n is skewed by n stages.
- Output column k is deskewed by K-1-k stages.
- All results of one row SHALL emerge together on y_data.
REQ-022 State machine with three states, NOWGT (after reset), READY and LOAD.
- NOWGT -> LOAD on w_load && w_ready.
- READY -> LOAD on w_load && w_ready.
- LOAD -> READY after exactly 1 cycle.
- In LOAD, w_data is captured into all PE weight registers.
REQ-023 w_ready SHALL equal 1 in NOWGT, and 1 in READY with busy==0; otherwise 0. A w_load with w_ready low SHALL be ignored.
REQ-024 Pipeline advance signal adv = !(y_valid && !y_ready); every skew, PE and deskew register SHALL update only when adv is 1.
REQ-025 x_ready SHALL equal (state==READY) && adv && !w_load.
REQ-026 Latency: with y_ready held at 1, a row accepted at cycle t SHALL give y_valid=1 at cycle t+N+K. Throughput is one row per cycle.
REQ-027 While y_valid=1 and y_ready=0, y_data and y_valid SHALL hold stable and no row SHALL be accepted.
REQ-028 Output order SHALL equal acceptance order. No row SHALL be lost or duplicated, including under arbitrary x_valid/y_ready patterns.
REQ-029 busy SHALL be implemented with an in-flight counter.
- +1 on accept, -1 on delivery; both in one cycle leaves it unchanged.
- busy = (counter != 0).
REQ-030 Bubbles (cycles with no accept) SHALL propagate as invalid slots and never produce y_valid.
REQ-031 Changing w_data while w_ready==0 or outside LOAD SHALL have no effect on results.

Reset
REQ-032 While rst is high on a clock edge:
- state -> NOWGT;
- y_valid, x_ready, busy -> 0;
- y_data, rows_out -> 0;
- all valid tags, PE accumulators and weight registers -> 0.
REQ-033 Reset mid-stream SHALL discard every in-flight row; no y_valid SHALL appear until a new row is accepted after new weights are loaded.

Verification
Common setup for all scenarios: N=3, K=4, DATA_WIDTH=16, ACC_WIDTH=32.
REQ-034 Ones weights: load W(n,k)=1; send x=[1,2,3] at cycle t with y_ready=1 -> y_valid only at t+7, y_data=[6,6,6,6], rows_out=1, busy back to 0.
REQ-035 ReLU and sign: W(n,k)=k+1; send x=[-1,-2,-3] with relu_en=0, then the same row with relu_en=1 on the next cycle.
- First row -> [-6,-12,-18,-24].
- Second row -> [0,0,0,0], one cycle later.
REQ-036 Back-pressure: stream 10 rows x=[i,0,0] with W ones; hold y_ready=0 for 5 cycles after the first y_valid.
- x_ready=0 and y_data held stable during the stall.
- All 10 rows are delivered in order as [i,i,i,i].
- rows_out=10.
REQ-037 Weight-load lockout: assert w_load with W=2s while busy=1 -> w_ready=0 and the load is ignored, so in-flight rows use the old weights. Once busy=0, w_load is accepted and x=[1,1,1] -> [6,6,6,6].
REQ-038 Mid-stream reset: pulse rst for 1 cycle while 3 rows are in flight -> no y_valid ever appears for them; state is NOWGT; x_ready=0 until a new w_load.
REQ-039 Overflow wrap: W(0,0)=0x7FFF with all other weights 0; x=[0x7FFF,0,0] -> y[0]=0x3FFF0001, other elements 0.
